// File: rtl/spmv_iter_ctrl.sv
// -----------------------------------------------------------------------------
// spmv_iter_ctrl
//
// Sequences an iterative sparse matrix-vector solve. Each iteration enables
// the SpMV kernel until it reports completion, then spends one SWAP cycle
// flipping the ping-pong select of the iterate-vector RAMs and counting the
// iteration. After the requested number of iterations a one-cycle finished
// pulse is produced.
//
// Optional feature (compile-time macro SPMV_ITER_CTRL_TIMEOUT_EN):
//   per-iteration watchdog. When the kernel stays busy for TIMEOUT_CYCLES
//   RUN cycles, the solve is dropped and the sticky timeout flag is set.
//   With the macro undefined, timeout is constant 0 and RUN waits forever.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   start       in   single-cycle solve request (ignored while busy)
//   abort       in   cancels the solve in progress
//   num_iters   in   iteration count, sampled on accepted start
//   kernel_en   out  enable to the SpMV kernel
//   kernel_done in   iteration-complete pulse from the kernel
//   ping        out  ping-pong select, persists across solves
//   busy        out  state != IDLE (combinational)
//   finished    out  one-cycle pulse on normal completion
//   iter_count  out  completed iterations of the current/last solve
//   timeout     out  sticky watchdog flag
// -----------------------------------------------------------------------------
module spmv_iter_ctrl #(
  parameter  int MAX_ITERS      = 1024,
  parameter  int TIMEOUT_CYCLES = 65535,
  localparam int ITER_WIDTH     = $clog2(MAX_ITERS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ITER_WIDTH-1:0] num_iters,
  output logic                  kernel_en,
  input  logic                  kernel_done,
  output logic                  ping,
  output logic                  busy,
  output logic                  finished,
  output logic [ITER_WIDTH-1:0] iter_count,
  output logic                  timeout
);

  if (MAX_ITERS < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("spmv_iter_ctrl: MAX_ITERS and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SWAP = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [ITER_WIDTH-1:0] MAX_ITERS_W = ITER_WIDTH'(MAX_ITERS);

  state_t                  state_q, state_d;
  logic [ITER_WIDTH-1:0]   target_q, target_d;
  logic [ITER_WIDTH-1:0]   iter_d;
  logic [ITER_WIDTH-1:0]   iter_inc;
  logic [ITER_WIDTH-1:0]   num_iters_sat;
  logic                    kernel_en_d;
  logic                    ping_d;
  logic                    finished_d;
  logic                    start_acc;
  logic                    last_iter;
  logic                    wd_expired;

  assign start_acc     = (state_q == IDLE) && start;
  assign num_iters_sat = (num_iters > MAX_ITERS_W) ? MAX_ITERS_W : num_iters;
  assign iter_inc      = iter_count + 1'b1;
  assign last_iter     = (iter_inc == target_q);
  assign busy          = (state_q != IDLE);

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
`ifdef SPMV_ITER_CTRL_TIMEOUT_EN
  localparam int                  WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_WIDTH-1:0] WD_LAST  = WD_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [WD_WIDTH-1:0] wd_cnt;

  // Held at zero outside RUN, so every entry into RUN starts a fresh count.
  // wd_cnt == WD_LAST marks the TIMEOUT_CYCLES-th RUN cycle of the iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state_q != RUN) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign wd_expired = (state_q == RUN) && (wd_cnt == WD_LAST);

  // Sticky until the next accepted start. A late kernel_done or an abort in
  // the expiring cycle takes precedence and leaves the flag clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout <= 1'b0;
    end else if (start_acc) begin
      timeout <= 1'b0;
    end else if (wd_expired && !abort && !kernel_done) begin
      timeout <= 1'b1;
    end
  end
`else
  assign wd_expired = 1'b0;
  assign timeout    = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        // abort is a don't-care here: a start in the same cycle is accepted.
        if (start) begin
          state_d = (num_iters == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (kernel_done) begin
          state_d = SWAP;
        end else if (wd_expired) begin
          state_d = IDLE;
        end
      end
      SWAP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (last_iter) begin
          state_d = FIN;
        end else begin
          state_d = RUN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic (next values of the registered outputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    // kernel_en follows the state being entered, so it rises with RUN and
    // drops on the same edge that leaves RUN (done, abort or watchdog).
    kernel_en_d = (state_d == RUN);
    // finished lands in the cycle after FIN; an abort during FIN cancels it.
    finished_d  = (state_q == FIN) && !abort;
    ping_d      = ping;
    iter_d      = iter_count;
    target_d    = target_q;

    if (start_acc && (num_iters != '0)) begin
      target_d = num_iters_sat;
      iter_d   = '0;
    end

    // Leaving SWAP commits the iteration; an abort freezes ping/iter_count.
    if ((state_q == SWAP) && !abort) begin
      ping_d = ~ping;
      iter_d = iter_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kernel_en  <= 1'b0;
      ping       <= 1'b0;
      finished   <= 1'b0;
      iter_count <= '0;
      target_q   <= '0;
    end else begin
      kernel_en  <= kernel_en_d;
      ping       <= ping_d;
      finished   <= finished_d;
      iter_count <= iter_d;
      target_q   <= target_d;
    end
  end

endmodule

// File: doc/spmv_iter_ctrl.md
SPMV_ITER_CTRL -- requirements
Module: spmv_iter_ctrl

Interface
REQ-001 SHALL have parameter MAX_ITERS, default 1024, the largest accepted iteration count.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535, the watchdog limit in cycles per iteration (used only under REQ-030).
REQ-003 SHALL have localparam ITER_WIDTH = $clog2(MAX_ITERS+1).
REQ-004 SHALL have the following ports, one per line:
- clk  input  1  single clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a solve.
- abort  input  1  cancels the solve in progress.
- num_iters  input  ITER_WIDTH  iteration count; sampled on accepted start.
- kernel_en  output  1  enable to the SpMV kernel.
- kernel_done  input  1  iteration-complete pulse from the kernel.
- ping  output  1  ping-pong select to the iterate vector RAMs.
- busy  output  1  high in any state except IDLE.
- finished  output  1  one-cycle pulse on normal completion.
- iter_count  output  ITER_WIDTH  number of completed iterations.
- timeout  output  1  sticky watchdog flag; tied 0 when REQ-030 is compiled out.

Function
REQ-005 SHALL implement the FSM states IDLE, RUN, SWAP and FIN.
REQ-006 In IDLE, start=1 with num_iters!=0 SHALL latch num_iters, clear iter_count, clear timeout and enter RUN; kernel_en SHALL be high in the cycle after start.
REQ-007 In IDLE, start=1 with num_iters==0 SHALL go to FIN; kernel_en SHALL stay low and ping SHALL be unchanged.
REQ-008 A num_iters value greater than MAX_ITERS SHALL saturate to MAX_ITERS when latched.
REQ-009 In RUN, kernel_en SHALL be held high until kernel_done is sampled high; the next state SHALL then be SWAP, with kernel_en low in SWAP.
REQ-010 In SWAP, ping SHALL toggle and iter_count SHALL increment, both registered on exit from SWAP.
REQ-011 SWAP SHALL go to FIN when the incremented iter_count equals the latched count; otherwise it SHALL return to RUN.
REQ-012 Minimum per-iteration overhead SHALL be one cycle (SWAP) between a sampled kernel_done and the next kernel_en high.
REQ-013 FIN SHALL assert finished for exactly one cycle and then go to IDLE.
REQ-014 start SHALL be ignored while busy=1.
REQ-015 kernel_done SHALL be ignored in IDLE, SWAP and FIN.
REQ-016 abort=1 in RUN, SWAP or FIN SHALL:
- force IDLE on the next edge;
- drop kernel_en in that cycle;
- suppress finished;
- keep ping and iter_count at their current values.
REQ-017 If abort and kernel_done are high in the same RUN cycle, abort SHALL win: no SWAP, no ping toggle.
REQ-018 If abort and start are high in the same IDLE cycle, start SHALL be accepted.
REQ-019 busy SHALL be combinational from the state register (state != IDLE); all other outputs SHALL be registered.
REQ-020 ping SHALL persist across solves so that the next solve resumes on the last-written vector.

Reset
REQ-021 rst_n low SHALL asynchronously force:
- state = IDLE;
- kernel_en = 0, ping = 0, finished = 0, iter_count = 0, timeout = 0;
- the latched count and the watchdog counter = 0.
REQ-022 Reset asserted mid-solve SHALL abandon the solve with no finished pulse.
REQ-023 After reset deassertion, the first accepted start SHALL behave per REQ-006.

Configuration
REQ-030 Macro SPMV_ITER_CTRL_TIMEOUT_EN SHALL compile the watchdog in or out.
- Defined: a counter SHALL clear on entry to RUN and increment each RUN cycle. If it reaches TIMEOUT_CYCLES without kernel_done, the block SHALL drop kernel_en, set timeout (sticky until the next accepted start) and go to IDLE without a finished pulse.
- Undefined: the counter SHALL be absent, timeout SHALL be constant 0, and RUN SHALL wait for kernel_done indefinitely.

Verification
REQ-040 Bench SHALL cover: reset, then start with num_iters=3, kernel_done 5 cycles after each kernel_en rise -> three kernel_en periods, ping 0->1->0->1, iter_count=3, one finished pulse, busy low afterwards.
REQ-041 Bench SHALL cover: start with num_iters=0 -> finished pulse 2 cycles after start, kernel_en never high, ping unchanged.
REQ-042 Bench SHALL cover: num_iters=4, abort in the same cycle as the 2nd kernel_done -> IDLE next cycle, iter_count=1, ping=1, no finished pulse.
REQ-043 Bench SHALL cover: start pulsed during RUN and kernel_done pulsed in IDLE -> no state change, no counter change.
REQ-044 Bench SHALL cover: with SPMV_ITER_CTRL_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, kernel_done withheld -> kernel_en low after 16 RUN cycles, timeout=1, busy=0; the next start clears timeout.
REQ-045 Bench SHALL cover: rst_n pulsed low mid-RUN -> all outputs at reset values immediately, no finished pulse.
